// File: rtl/ex_operand_stage_pkg.sv
// Shared CPU constants and ALUOp encodings used by the EX operand stage.
//   CPU_XLEN : default datapath width
//   CPU_REGW : default register-index width
//   alu_op_e : 4-bit ALUOp codes; aluop_nop is loaded into bubbles
package ex_operand_stage_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam int unsigned CPU_REGW = 5;

    typedef enum logic [3:0] {
        aluop_add  = 4'h0,
        aluop_sub  = 4'h1,
        aluop_and  = 4'h2,
        aluop_or   = 4'h3,
        aluop_xor  = 4'h4,
        aluop_sll  = 4'h5,
        aluop_srl  = 4'h6,
        aluop_sra  = 4'h7,
        aluop_slt  = 4'h8,
        aluop_sltu = 4'h9,
        aluop_lui  = 4'ha,
        aluop_nop  = 4'hf
    } alu_op_e;

endpackage

// File: rtl/ex_forward_mux.sv
// Priority operand forwarding for one source register.
//   rs, rs_data                  : registered source index and data
//   exmem_rd/reg_write/result    : EX/MEM producer (highest priority)
//   memwb_rd/reg_write/result    : MEM/WB producer
//   fwd                          : selected operand value
// Index 0 never forwards, so x0 always reads its registered value.
module ex_forward_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd
);

    logic exmem_hit;
    logic memwb_hit;

    always_comb begin
        exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
        memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);
        fwd       = rs_data;
        if (exmem_hit) begin
            fwd = exmem_result;
        end else if (memwb_hit) begin
            fwd = memwb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX stage register with operand forwarding and load-use detection.
//   clk, rst             : clock, synchronous active-high reset
//   stall, flush         : hold the stage / insert a bubble
//   id_*                 : decoded instruction fields from ID
//   exmem_*, memwb_*     : downstream producers for forwarding
//   ex_*                 : registered instruction presented to EX, with
//                          forwarded ALU operands and store data
//   load_use_hazard      : combinational; EX load feeds the ID instruction
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = CPU_XLEN,
    parameter int unsigned REGW = CPU_REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src_a,
    input  logic            id_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_hazard
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alu_op;
        logic            src_a;
        logic            src_b;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } stage_t;

    stage_t          r;
    stage_t          bubble;
    stage_t          id_stage;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    always_comb begin
        bubble        = '0;
        bubble.alu_op = aluop_nop;
    end

    always_comb begin
        id_stage.valid     = 1'b1;
        id_stage.pc        = id_pc;
        id_stage.rs1_data  = id_rs1_data;
        id_stage.rs2_data  = id_rs2_data;
        id_stage.imm       = id_imm;
        id_stage.rs1       = id_rs1;
        id_stage.rs2       = id_rs2;
        id_stage.rd        = id_rd;
        id_stage.alu_op    = id_alu_op;
        id_stage.src_a     = id_src_a;
        id_stage.src_b     = id_src_b;
        id_stage.reg_write = id_reg_write;
        id_stage.mem_read  = id_mem_read;
        id_stage.mem_write = id_mem_write;
    end

    always_comb begin
        load_use_hazard = r.valid && r.mem_read && (r.rd != '0) && id_valid &&
                          ((r.rd == id_rs1) || (r.rd == id_rs2));
    end

    // While stalled, the operand data is refreshed with the forwarded value so
    // a producer that retires past MEM/WB during the stall is still captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= bubble;
        end else if (flush) begin
            r <= bubble;
        end else if (stall) begin
            r.rs1_data <= fwd1;
            r.rs2_data <= fwd2;
        end else if (load_use_hazard || !id_valid) begin
            r <= bubble;
        end else begin
            r <= id_stage;
        end
    end

    ex_forward_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_rs1 (
        .rs              (r.rs1),
        .rs_data         (r.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (fwd1)
    );

    ex_forward_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_rs2 (
        .rs              (r.rs2),
        .rs_data         (r.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (fwd2)
    );

    always_comb begin
        ex_valid      = r.valid;
        ex_alu_a      = r.src_a ? r.pc  : fwd1;
        ex_alu_b      = r.src_b ? r.imm : fwd2;
        ex_alu_op     = r.alu_op;
        ex_store_data = fwd2;
        ex_pc         = r.pc;
        ex_rd         = r.rd;
        ex_reg_write  = r.reg_write;
        ex_mem_read   = r.mem_read;
        ex_mem_write  = r.mem_write;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [3:0]      id_alu_op;
    logic            id_src_a;
    logic            id_src_b;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic [REGW-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [REGW-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic [3:0]      ex_alu_op;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            load_use_hazard;

    int unsigned n_compared;
    int unsigned n_mismatched;

    ex_operand_stage #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_op       (id_alu_op),
        .id_src_a        (id_src_a),
        .id_src_b        (id_src_b),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_alu_a        (ex_alu_a),
        .ex_alu_b        (ex_alu_b),
        .ex_alu_op       (ex_alu_op),
        .ex_store_data   (ex_store_data),
        .ex_pc           (ex_pc),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .load_use_hazard (load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic id_instr(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                            input logic [REGW-1:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [3:0] op,
                            input logic mrd, input logic [31:0] pc);
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_alu_op    = op;
        id_mem_read  = mrd;
        id_reg_write = 1'b1;
        id_mem_write = 1'b0;
        id_src_a     = 1'b0;
        id_src_b     = 1'b0;
        id_imm       = 32'h0;
        id_pc        = pc;
    endtask

    task automatic clear_fwd();
        exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        id_valid = 1'b0;
        clear_fwd();

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid",  {31'b0, ex_valid}, 32'h0);
        check("rst_aluop",  {28'b0, ex_alu_op}, 32'hf);
        check("rst_alu_a",  ex_alu_a, 32'h0);
        check("rst_alu_b",  ex_alu_b, 32'h0);
        check("rst_pc",     ex_pc, 32'h0);
        check("rst_ctrl",   {27'b0, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write}, 32'h0);

        // add x3,x1,x2 with 5 and 7, no forwarding
        id_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'h0, 1'b0, 32'h40);
        tick();
        check("add_valid", {31'b0, ex_valid}, 32'h1);
        check("add_alu_a", ex_alu_a, 32'd5);
        check("add_alu_b", ex_alu_b, 32'd7);
        check("add_rd",    {27'b0, ex_rd}, 32'd3);
        check("add_pc",    ex_pc, 32'h40);
        check("add_op",    {28'b0, ex_alu_op}, 32'h0);
        check("add_rw",    {31'b0, ex_reg_write}, 32'h1);

        // Forwarding priority on rs1=x3
        id_instr(5'd3, 5'd0, 5'd7, 32'h99, 32'h0, 4'h1, 1'b0, 32'h44);
        tick();
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h10;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h20;
        #1;
        check("fwd_exmem", ex_alu_a, 32'h10);
        exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb", ex_alu_a, 32'h20);
        memwb_reg_write = 1'b0;
        #1;
        check("fwd_none", ex_alu_a, 32'h99);

        // x0 never forwards
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hdead;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'hbeef;
        id_instr(5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 4'h0, 1'b0, 32'h48);
        tick();
        check("x0_alu_a", ex_alu_a, 32'h0);
        check("x0_alu_b", ex_alu_b, 32'h0);
        clear_fwd();

        // lw x4 in EX, add reading x4 in ID -> hazard, then bubble
        id_instr(5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 4'h0, 1'b1, 32'h50);
        tick();
        id_instr(5'd4, 5'd2, 5'd5, 32'h1, 32'h2, 4'h0, 1'b0, 32'h54);
        #1;
        check("lu_hazard", {31'b0, load_use_hazard}, 32'h1);
        // stall together with hazard holds the load
        stall = 1'b1;
        tick();
        check("lu_stall_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_stall_rd",    {27'b0, ex_rd}, 32'd4);
        check("lu_stall_mrd",   {31'b0, ex_mem_read}, 32'h1);
        stall = 1'b0;
        tick();
        check("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        check("lu_bubble_op",    {28'b0, ex_alu_op}, 32'hf);
        check("lu_clear",        {31'b0, load_use_hazard}, 32'h0);
        tick();
        check("lu_retry_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_retry_rd",    {27'b0, ex_rd}, 32'd5);

        // Load via x0 destination is not a hazard
        id_instr(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h58);
        tick();
        id_instr(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5c);
        #1;
        check("lu_x0", {31'b0, load_use_hazard}, 32'h0);

        // id_valid=0 loads a bubble
        id_valid = 1'b0;
        tick();
        check("idle_valid", {31'b0, ex_valid}, 32'h0);

        // Long stall: producer of x5 passes EX/MEM then MEM/WB
        id_instr(5'd1, 5'd5, 5'd6, 32'h11, 32'h0, 4'h2, 1'b0, 32'h60);
        tick();
        stall = 1'b1;
        id_instr(5'd9, 5'd9, 5'd9, 32'hff, 32'hff, 4'h3, 1'b0, 32'h64);
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h55;
        tick();
        clear_fwd();
        memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h55;
        tick();
        clear_fwd();
        tick();
        check("stall_alu_b", ex_alu_b, 32'h55);
        check("stall_store", ex_store_data, 32'h55);
        check("stall_alu_a", ex_alu_a, 32'h11);
        check("stall_rd",    {27'b0, ex_rd}, 32'd6);
        check("stall_op",    {28'b0, ex_alu_op}, 32'h2);

        // flush with stall -> bubble
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_op",    {28'b0, ex_alu_op}, 32'hf);
        check("flush_alu_b", ex_alu_b, 32'h0);

        // rst mid-stall discards the held instruction
        stall = 1'b0;
        id_instr(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 4'h0, 1'b0, 32'h70);
        tick();
        stall = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        id_valid = 1'b0;
        check("rststall_valid", {31'b0, ex_valid}, 32'h0);
        check("rststall_op",    {28'b0, ex_alu_op}, 32'hf);
        check("rststall_a",     ex_alu_a, 32'h0);
        check("rststall_pc",    ex_pc, 32'h0);
        check("rststall_rd",    {27'b0, ex_rd, ex_reg_write, 2'b0}, 32'h0);

        // auipc-style: src_a=pc, src_b=imm, store data still fwd2
        id_instr(5'd1, 5'd2, 5'd10, 32'h33, 32'h77, 4'h0, 1'b0, 32'h100);
        id_src_a = 1'b1;
        id_src_b = 1'b1;
        id_imm   = 32'h1;
        tick();
        check("auipc_a",     ex_alu_a, 32'h100);
        check("auipc_b",     ex_alu_b, 32'h1);
        check("auipc_store", ex_store_data, 32'h77);
        exmem_rd = 5'd2; exmem_reg_write = 1'b1; exmem_result = 32'hab;
        #1;
        check("auipc_store_fwd", ex_store_data, 32'hab);
        check("auipc_b_fwd",     ex_alu_b, 32'h1);
        clear_fwd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, which sets the datapath width.
REQ-002 SHALL have parameter REGW, default 5, which sets the register-index width.
REQ-003 SHALL provide the following ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; every register updates on its rising edge
  rst  in  1  synchronous, active-high reset
  stall  in  1  hold the stage register
  flush  in  1  insert a bubble
  id_valid  in  1  ID holds an instruction
  id_pc  in  XLEN  instruction PC
  id_rs1_data, id_rs2_data  in  XLEN  register-file read data
  id_imm  in  XLEN  sign-extended immediate
  id_rs1, id_rs2, id_rd  in  REGW  register indices
  id_alu_op  in  4  ALUOp code
  id_src_a  in  1  0 selects rs1, 1 selects PC
  id_src_b  in  1  0 selects rs2, 1 selects immediate
  id_reg_write, id_mem_read, id_mem_write  in  1  control bits
  exmem_rd  in  REGW, exmem_reg_write  in  1, exmem_result  in  XLEN  EX/MEM producer
  memwb_rd  in  REGW, memwb_reg_write  in  1, memwb_result  in  XLEN  MEM/WB producer
  ex_valid  out  1  EX holds a live instruction
  ex_alu_a, ex_alu_b  out  XLEN  ALU operands A and B
  ex_alu_op  out  4  ALUOp code to the ALU
  ex_store_data  out  XLEN  forwarded rs2 value for stores
  ex_pc  out  XLEN, ex_rd  out  REGW
  ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits
  load_use_hazard  out  1  combinational; upstream uses it to stall IF/ID

Function
REQ-004 SHALL register all id_* fields in one stage register, so they appear on the ex_* outputs one cycle after capture.
REQ-005 SHALL choose the next register value by this priority: rst, then flush (bubble), then stall (hold), then load_use_hazard (bubble), then load from ID.
REQ-006 SHALL, on a bubble, set ex_valid, reg_write, mem_read, mem_write, rd, pc and the data fields to 0, and set alu_op to ALUOp_nop.
REQ-007 SHALL load a bubble when id_valid=0.
REQ-008 SHALL drive load_use_hazard = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2), evaluated combinationally.
REQ-009 SHALL compute forwarded rs1 (fwd1) combinationally from the registered rs1 index and data:
  - EX/MEM match first: exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1.
  - Otherwise the MEM/WB match, using the same rule.
  - Otherwise the registered data.
REQ-010 SHALL compute forwarded rs2 (fwd2) with the same rule applied to rs2.
REQ-011 SHALL never forward for index 0; x0 reads as the registered value, which is 0.
REQ-012 SHALL drive ex_alu_a = src_a ? pc : fwd1.
REQ-013 SHALL drive ex_alu_b = src_b ? imm : fwd2.
REQ-014 SHALL drive ex_store_data = fwd2 regardless of src_b.
REQ-015 SHALL, while stall=1, write fwd1 and fwd2 back into the registered rs1/rs2 data while holding every other field, so a producer that retires during a long stall is not lost.
REQ-016 SHALL pass the ALUOp code through unmodified.
REQ-017 SHALL perform no arithmetic; all data widths are exactly XLEN.
REQ-018 SHALL, when flush=1 and stall=1 in the same cycle, produce a bubble.
REQ-019 SHALL, when stall=1 and load_use_hazard=1 in the same cycle, hold the register, with no bubble.

Reset
REQ-020 SHALL, on clk with rst=1, drive every output register to the bubble value of REQ-006 and clear the registered rs1/rs2 indices and data to 0.
REQ-021 SHALL let rst override stall and flush.
REQ-022 SHALL, when rst is asserted mid-stall, have the held instruction discarded by the following cycle.

Structure
REQ-023 SHALL take the ALUOp encodings, including ALUOp_nop, and the XLEN/REGW constants from the shared CPU package or defines, and SHALL not redefine them locally.
REQ-024 SHALL instantiate one sub-module, ex_forward_mux, twice (rs1 and rs2), implementing the priority selection of REQ-009.
REQ-025 SHALL be sized for 120-400 lines of RTL with no memories.

Verification
REQ-026 SHALL cover add x3,x1,x2 with rs1_data=5 and rs2_data=7 and no matches -> next cycle ex_alu_a=5, ex_alu_b=7, ex_valid=1.
REQ-027 SHALL cover rs1=3 with exmem_rd=3 (result 0x10) and memwb_rd=3 (result 0x20), both with reg_write=1 -> ex_alu_a=0x10; with exmem_reg_write=0 -> ex_alu_a=0x20; with rs1=0 -> ex_alu_a=0.
REQ-028 SHALL cover an EX lw to x4 followed by an ID add reading x4 -> load_use_hazard=1 and the next cycle is a bubble (ex_valid=0, ex_alu_op=ALUOp_nop).
REQ-029 SHALL cover stall held 3 cycles with the producer of rs2=x5 (value 0x55) passing through EX/MEM and then MEM/WB -> after release ex_alu_b=0x55.
REQ-030 SHALL cover flush=1 with stall=1 -> bubble; rst=1 with stall=1 -> all outputs at reset values next cycle.
REQ-031 SHALL cover auipc-style src_a=1, src_b=1 with pc=0x100 and imm=0x1 -> ex_alu_a=0x100, ex_alu_b=0x1, ex_store_data=fwd2.
